// File: rtl/data_memory.sv
// Multi-cycle RV32 data memory with byte/halfword/word access and a
// CPU stall handshake (IDLE -> BUSY -> ACK).
module data_memory #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] MEM_ADDRESS,
  input  logic [31:0] MEM_WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSYWAIT,
  output logic        ERROR
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW+1:0] addr_q;
  logic [31:0]   data_q;
  logic [2:0]    f3_q;
  logic          wr_q;

  logic [31:0]   mem [DEPTH];

  logic          req;
  logic          done;
  logic [1:0]    off;
  logic [AW-1:0] idx;
  logic          mis;
  logic          bad_f3;
  logic          err;
  logic [31:0]   word;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   load_val;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic          unused_addr;

  assign unused_addr = ^MEM_ADDRESS[31:AW+2];

  assign req  = MEM_READ | MEM_WRITE;
  assign done = (state == BUSY) && (cnt == '0);

  assign BUSYWAIT = RESET &
    (((state == IDLE) && req) || (state == BUSY));

  assign off = addr_q[1:0];
  assign idx = addr_q[AW+1:2];

  assign mis = ((f3_q[1:0] == 2'd1) && off[0]) ||
               ((f3_q[1:0] == 2'd2) && (off != 2'd0));

  // Stores only know B/H/W; loads also have the unsigned variants.
  assign bad_f3 = wr_q ? (f3_q > 3'd2)
                       : ((f3_q[1:0] == 2'd3) || (f3_q == 3'd6));

  assign err = mis | bad_f3;

  assign word   = mem[idx];
  assign byte_v = 8'(word >> {off, 3'b000});
  assign half_v = addr_q[1] ? word[31:16] : word[15:0];

  always_comb begin
    load_val = word;
    unique case (1'b1)
      f3_q == 3'd0: load_val = {{24{byte_v[7]}}, byte_v};
      f3_q == 3'd4: load_val = {24'b0, byte_v};
      f3_q == 3'd1: load_val = {{16{half_v[15]}}, half_v};
      f3_q == 3'd5: load_val = {16'b0, half_v};
      default:      load_val = word;
    endcase
  end

  always_comb begin
    be    = 4'hf;
    wlane = data_q;
    case (f3_q[1:0])
      2'd0: begin
        be    = 4'b0001 << off;
        wlane = {4{data_q[7:0]}};
      end
      2'd1: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{data_q[15:0]}};
      end
      default: begin
        be    = 4'hf;
        wlane = data_q;
      end
    endcase
  end

  // Storage has no reset so contents survive a core reset.
  always_ff @(posedge CLK) begin
    if (done && wr_q && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      READ_DATA <= '0;
      ERROR     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      f3_q      <= '0;
      wr_q      <= 1'b0;
    end else begin
      ERROR <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            addr_q <= MEM_ADDRESS[AW+1:0];
            data_q <= MEM_WRITE_DATA;
            f3_q   <= FUNCT3;
            wr_q   <= MEM_WRITE;
            cnt    <= CW'(LATENCY - 1);
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= ACK;
            ERROR <= err;
            if (!wr_q) READ_DATA <= err ? '0 : load_val;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: directed spec scenarios, random
// traffic against a byte-level memory model, and a LATENCY=1 instance.
module tb_data_memory;

  localparam int DEPTH = 256;
  localparam int LAT   = 4;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MEM_READ, MEM_WRITE;
  logic [2:0]  FUNCT3;
  logic [31:0] MEM_ADDRESS, MEM_WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSYWAIT, ERROR;

  logic        b_read;
  logic [31:0] b_rdata;
  logic        b_busy, b_err;

  int checks = 0;
  int errors = 0;

  exp_t        expq[$];
  bit   [31:0] model_mem [DEPTH];
  logic [31:0] last_rd = '0;

  always #5 CLK = ~CLK;

  data_memory #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .CLK(CLK), .RESET(RESET),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .FUNCT3(FUNCT3), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITE_DATA(MEM_WRITE_DATA),
    .READ_DATA(READ_DATA), .BUSYWAIT(BUSYWAIT), .ERROR(ERROR)
  );

  data_memory #(.DEPTH(4), .LATENCY(1)) u_dut1 (
    .CLK(CLK), .RESET(RESET),
    .MEM_READ(b_read), .MEM_WRITE(1'b0),
    .FUNCT3(3'd2), .MEM_ADDRESS(32'h0),
    .MEM_WRITE_DATA(32'h0),
    .READ_DATA(b_rdata), .BUSYWAIT(b_busy), .ERROR(b_err)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t predict(bit rd_in, bit wr, logic [2:0] f3,
                                   logic [31:0] a, logic [31:0] d);
    exp_t        e;
    int          size, idx, off;
    bit          legal, err, rd;
    logic [31:0] v;
    rd  = rd_in && !wr;
    idx = int'((a >> 2) % DEPTH);
    off = int'(a % 4);
    case (f3[1:0])
      2'd0:    size = 1;
      2'd1:    size = 2;
      default: size = 4;
    endcase
    if (wr) legal = (f3 <= 3'd2);
    else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err = !legal || (off % size != 0);
    if (wr && !err) begin
      for (int k = 0; k < size; k++)
        model_mem[idx][8*(off+k) +: 8] = d[8*k +: 8];
    end
    if (rd) begin
      if (err) begin
        last_rd = '0;
      end else begin
        v = model_mem[idx] >> (8 * off);
        if (size == 1)
          v = f3[2] ? {24'b0, v[7:0]} : {{24{v[7]}}, v[7:0]};
        else if (size == 2)
          v = f3[2] ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        last_rd = v;
      end
    end
    e.err   = err;
    e.rdata = last_rd;
    return e;
  endfunction

  // Monitor: counts stall length and checks each ACK against the queue.
  initial begin
    int   cnt;
    exp_t e;
    cnt = 0;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        cnt = 0;
      end else if (BUSYWAIT) begin
        cnt++;
        if (ERROR !== 1'b0) chk("error_busy", 32'(ERROR), 32'd0);
      end else if (cnt > 0) begin
        chk("busy_len", cnt, LAT + 1);
        if (expq.size() == 0) begin
          chk("ack_unexpected", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          chk("rdata", READ_DATA, e.rdata);
          chk("error", 32'(ERROR), 32'(e.err));
        end
        cnt = 0;
      end else if (ERROR !== 1'b0) begin
        chk("error_idle", 32'(ERROR), 32'd0);
      end
    end
  end

  task automatic wait_ack();
    bit seen;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLK);
      if (!BUSYWAIT) begin
        seen = 1;
        break;
      end
      @(posedge CLK); #1;
      MEM_ADDRESS    = $urandom;
      MEM_WRITE_DATA = $urandom;
      FUNCT3         = 3'($urandom);
    end
    if (!seen) chk("wait_ack_timeout", 32'd1, 32'd0);
  endtask

  task automatic access(bit rd, bit wr, logic [2:0] f3,
                        logic [31:0] a, logic [31:0] d,
                        bit use_k = 0, logic [31:0] k = '0);
    exp_t e;
    @(posedge CLK); #1;
    MEM_READ       = rd;
    MEM_WRITE      = wr;
    FUNCT3         = f3;
    MEM_ADDRESS    = a;
    MEM_WRITE_DATA = d;
    e = predict(rd, wr, f3, a, d);
    if (use_k) e.rdata = k;
    expq.push_back(e);
    wait_ack();
    @(posedge CLK); #1;
    MEM_READ  = 1'b0;
    MEM_WRITE = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bit pat [6] = '{1, 1, 0, 1, 1, 0};
    RESET = 1'b0;
    MEM_READ = 0; MEM_WRITE = 0; FUNCT3 = 0;
    MEM_ADDRESS = 0; MEM_WRITE_DATA = 0;
    b_read = 0;

    // Request held through reset, then accepted on release.
    repeat (2) @(posedge CLK);
    #1;
    MEM_READ = 1; FUNCT3 = 3'd2; MEM_ADDRESS = 32'h0;
    @(negedge CLK);
    chk("rst_busy", 32'(BUSYWAIT), 32'd0);
    chk("rst_rdata", READ_DATA, 32'd0);
    chk("rst_error", 32'(ERROR), 32'd0);
    expq.push_back(predict(1, 0, 3'd2, 32'h0, 32'h0));
    @(posedge CLK); #1;
    RESET = 1'b1;
    wait_ack();
    @(posedge CLK); #1;
    MEM_READ = 0;

    access(0, 1, 3'd2, 32'h10, 32'hDEADBEEF);
    access(1, 0, 3'd2, 32'h10, 32'h0, 1, 32'hDEADBEEF);
    access(0, 1, 3'd0, 32'h11, 32'h0000007F);
    access(1, 0, 3'd0, 32'h11, 32'h0, 1, 32'h0000007F);
    access(1, 0, 3'd4, 32'h13, 32'h0, 1, 32'h000000DE);
    access(1, 0, 3'd1, 32'h12, 32'h0, 1, 32'hFFFFDEAD);
    access(1, 0, 3'd2, 32'h12, 32'h0, 1, 32'h0);
    access(0, 1, 3'd1, 32'h13, 32'hFFFF, 1, 32'h0);
    access(1, 0, 3'd2, 32'h10, 32'h0, 1, 32'hDEAD7FEF);
    access(0, 1, 3'd2, 32'h400, 32'h12345678);
    access(1, 0, 3'd2, 32'h000, 32'h0, 1, 32'h12345678);
    access(1, 1, 3'd2, 32'h30, 32'hCAFEF00D, 1, 32'h12345678);
    access(1, 0, 3'd2, 32'h30, 32'h0, 1, 32'hCAFEF00D);
    access(1, 0, 3'd3, 32'h30, 32'h0, 1, 32'h0);
    access(0, 1, 3'd4, 32'h30, 32'h1);
    access(1, 0, 3'd5, 32'h32, 32'h0, 1, 32'h0000CAFE);
    access(0, 1, 3'd2, 32'h20, 32'h11112222);

    // Reset pulse during BUSY of a store aborts it.
    @(posedge CLK); #1;
    MEM_WRITE = 1; FUNCT3 = 3'd2;
    MEM_ADDRESS = 32'h20; MEM_WRITE_DATA = 32'hAAAAAAAA;
    @(negedge CLK);
    @(posedge CLK);
    @(negedge CLK); #1;
    RESET = 1'b0;
    #1;
    chk("abort_busy", 32'(BUSYWAIT), 32'd0);
    MEM_WRITE = 0; MEM_READ = 1;
    last_rd = '0;
    @(negedge CLK);
    chk("abort_rdata", READ_DATA, 32'd0);
    chk("abort_held_busy", 32'(BUSYWAIT), 32'd0);
    expq.push_back(predict(1, 0, 3'd2, 32'h20, 32'h0));
    @(posedge CLK); #1;
    RESET = 1'b1;
    wait_ack();
    @(posedge CLK); #1;
    MEM_READ = 0;
    chk("abort_model", model_mem[8], 32'h11112222);

    repeat (150) begin
      int          kind;
      logic [2:0]  f3;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
      end else begin
        f3 = 3'($urandom);
      end
      a = ($urandom << 10) | 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      access(kind != 1, kind != 0, f3, a, $urandom);
    end

    repeat (3) @(posedge CLK);
    chk("queue_drain", expq.size(), 0);

    // LATENCY=1 instance with the read held across ACK.
    @(posedge CLK); #1;
    b_read = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk($sformatf("lat1_busy%0d", i), 32'(b_busy), 32'(pat[i]));
      chk($sformatf("lat1_err%0d", i), 32'(b_err), 32'd0);
    end
    @(posedge CLK); #1;
    b_read = 0;
    @(negedge CLK);
    chk("lat1_rdata", b_rdata, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
